// File: rtl/vga_scanout_reader_if.sv
// vga_scanout_reader_if: framebuffer read port, address out and colour back one clock later
interface vga_scanout_reader_if;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  modport master(output rd_addr, input rd_data);
  modport slave(input rd_addr, output rd_data);
endinterface

// File: rtl/vga_scanout_reader.sv
// vga_scanout_reader: 640x480@60 VGA timing with 4x4 upscaled scan-out of a 160x120 framebuffer
module vga_scanout_reader #(
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  vga_scanout_reader_if.master  fb,
  output logic                  frame_start,
  output logic                  VGA_CLK,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N,
  output logic [9:0]            VGA_R,
  output logic [9:0]            VGA_G,
  output logic [9:0]            VGA_B
);
  localparam int H_TOTAL = 640 + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = 480 + V_FP + V_SYNC + V_BP;
  logic        phase, first, pix_en, h_last, v_last, active, hs, vs;
  logic [9:0]  h_cnt, v_cnt;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [14:0] addr;
  assign pix_en     = phase;
  assign VGA_CLK    = phase;
  assign VGA_SYNC_N = 1'b0;
  assign h_last     = h_cnt == 10'(H_TOTAL - 1);
  assign v_last     = v_cnt == 10'(V_TOTAL - 1);
  assign active     = (h_cnt < 10'd640) && (v_cnt < 10'd480);
  assign hs         = !((h_cnt >= 10'(640 + H_FP)) && (h_cnt < 10'(640 + H_FP + H_SYNC)));
  assign vs         = !((v_cnt >= 10'(480 + V_FP)) && (v_cnt < 10'(480 + V_FP + V_SYNC)));
  assign x          = h_cnt[9:2];
  assign y          = v_cnt[8:2];
  // y*160 as two shifts; the result never exceeds 19199 so 15 bits hold it exactly
  assign addr       = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
  assign fb.rd_addr = active ? addr : '0;
  // Colour/sync are loaded on the pix_en edge that retires the pixel whose address
  // went out one period earlier, so all pins share the same one-pixel latency.
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      phase       <= 1'b0;
      first       <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      phase       <= ~phase;
      frame_start <= pix_en && (first || (h_last && v_last));
      if (pix_en) begin
        first       <= 1'b0;
        h_cnt       <= h_last ? '0 : h_cnt + 10'd1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        VGA_HS      <= hs;
        VGA_VS      <= vs;
        VGA_BLANK_N <= active;
        VGA_R       <= active ? {10{fb.rd_data[2]}} : '0;
        VGA_G       <= active ? {10{fb.rd_data[1]}} : '0;
        VGA_B       <= active ? {10{fb.rd_data[0]}} : '0;
      end
    end
endmodule

// File: tb/tb_vga_scanout_reader.sv
// tb_vga_scanout_reader: linear-pixel-index reference model, address table and multi-cycle corner sequences
module tb_vga_scanout_reader;
  localparam int HT = 800, VT = 525, FRAME = HT * VT;
  logic CLOCK_50 = 1'b0, reset = 1'b0;
  logic frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;
  logic [2:0] mem [0:32767];
  logic [9:0] fh, fv;
  int checks = 0, errors = 0;
  int n_hs, n_vs, n_bl, n_fs;
  bit m_rst, m_ph, m_fs, m_first;
  int m_p, m_shown;
  logic [2:0] m_col;
  typedef struct { int h; int v; int addr; } vec_t;
  vec_t tbl [10];

  vga_scanout_reader_if fb();
  vga_scanout_reader dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .fb(fb.master), .frame_start(frame_start),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) fb.rd_data <= mem[fb.rd_addr];

  wire [50:0] pins = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start,
                      VGA_R, VGA_G, VGA_B, fb.rd_addr};

  function automatic int addr_of(int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return (h < 640 && v < 480) ? (v / 4) * 160 + h / 4 : 0;
  endfunction

  function automatic logic [50:0] exp_pins();
    int h, v, a;
    logic act;
    if (m_rst) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0, 15'd0};
    a = addr_of(m_p);
    if (m_shown < 0) return {m_ph, 1'b1, 1'b1, 1'b0, 1'b0, m_fs, 30'd0, a[14:0]};
    h = m_shown % HT;
    v = m_shown / HT;
    act = h < 640 && v < 480;
    return {m_ph, !(h >= 656 && h < 752), !(v >= 490 && v < 492), act, 1'b0, m_fs,
            {10{act & m_col[2]}}, {10{act & m_col[1]}}, {10{act & m_col[0]}}, a[14:0]};
  endfunction

  task automatic check(input string name, input logic [50:0] act, input logic [50:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 32768; i++)
      mem[i] = mode == 0 ? 3'($urandom) : mode == 1 ? 3'd7 : mode == 2 ? 3'(i) : 3'd0;
  endtask

  task automatic model_reset();
    m_rst = 1; m_ph = 0; m_p = 0; m_shown = -1; m_fs = 0; m_first = 1;
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    if (!m_rst) begin
      m_fs = 0;
      if (m_ph) begin
        m_shown = m_p;
        m_col = mem[addr_of(m_p)];
        m_fs = m_first || m_p == FRAME - 1;
        m_first = 0;
        m_p = (m_p + 1) % FRAME;
      end
      m_ph = !m_ph;
    end
    @(negedge CLOCK_50);
    check("pins", pins, exp_pins());
    if (!VGA_HS) n_hs++;
    if (!VGA_VS) n_vs++;
    if (VGA_BLANK_N) n_bl++;
    if (frame_start) n_fs++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr();
    n_hs = 0; n_vs = 0; n_bl = 0; n_fs = 0;
  endtask

  // Relocate the scan position just after a pix_en edge so the next edge starts from (h, v)
  task automatic jump(input int h, input int v, input int mode);
    while (m_ph) cyc();
    fh = 10'(h);
    fv = 10'(v);
    force dut.h_cnt = fh;
    force dut.v_cnt = fv;
    m_p = v * HT + h;
    fill(mode);
    cyc();
    release dut.h_cnt;
    release dut.v_cnt;
  endtask

  initial begin
    tbl[0] = '{4, 8, 321};     tbl[1] = '{639, 479, 19199}; tbl[2] = '{0, 0, 0};
    tbl[3] = '{3, 3, 0};       tbl[4] = '{2, 1, 0};         tbl[5] = '{640, 0, 0};
    tbl[6] = '{100, 480, 0};   tbl[7] = '{799, 524, 0};     tbl[8] = '{5, 5, 161};
    tbl[9] = '{637, 4, 319};
    fill(0);
    model_reset();
    clr();
    run(3);
    fh = '0;
    fv = '0;
    force dut.h_cnt = fh;
    force dut.v_cnt = fv;
    for (int i = 0; i < 10; i++) begin
      fh = 10'(tbl[i].h);
      fv = 10'(tbl[i].v);
      @(negedge CLOCK_50);
      check($sformatf("addr_tbl%0d", i), 51'(fb.rd_addr), 51'(tbl[i].addr));
    end
    release dut.h_cnt;
    release dut.v_cnt;
    run(3);
    reset = 1'b1;
    m_rst = 0;
    run(4600);
    jump(0, 477, 1);
    clr();
    run(8000);
    check("blank_cnt", 51'(n_bl), 51'(3 * 1280));
    check("hs_cnt_a", 51'(n_hs), 51'(5 * 192));
    check("vs_cnt_a", 51'(n_vs), 51'd0);
    jump(0, 486, 3);
    clr();
    run(12800);
    check("vs_cnt", 51'(n_vs), 51'd3200);
    check("hs_cnt_b", 51'(n_hs), 51'(8 * 192));
    check("blank_cnt_b", 51'(n_bl), 51'd0);
    jump(790, 524, 2);
    clr();
    run(1800);
    check("wrap_pulses", 51'(n_fs), 51'd1);
    jump(790, 10, 0);
    clr();
    run(40);
    check("no_pulse_line", 51'(n_fs), 51'd0);
    jump(300, 200, 0);
    run(20);
    #5 reset = 1'b0;
    #1 model_reset();
    check("async_rst", pins, exp_pins());
    run(10);
    reset = 1'b1;
    m_rst = 0;
    clr();
    run(6);
    check("restart_pulse", 51'(n_fs), 51'd1);
    run(2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
